// File: rtl/sw_pkg.sv
// Shared constants, FSM encoding and helpers for the Smith-Waterman host bridge.
// SW_BRIDGE_CKSUM_EN adds a checksum byte to the result frame and doubles the error byte.
package sw_pkg;

  localparam int unsigned MAX_LEN = 128;
  localparam int unsigned SEQ_W   = 2 * MAX_LEN;
  localparam int unsigned SCORE_W = 10;
  localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;
  localparam int unsigned POS_W   = $clog2(MAX_LEN);
  localparam int unsigned CNT_W   = $clog2(MAX_LEN / 4) + 1;

  localparam logic [7:0] ERR_BYTE = 8'hEE;

`ifdef SW_BRIDGE_CKSUM_EN
  localparam int unsigned RESULT_BYTES = 5;
  localparam int unsigned ERR_BYTES    = 2;
`else
  localparam int unsigned RESULT_BYTES = 4;
  localparam int unsigned ERR_BYTES    = 1;
`endif

  localparam int unsigned FRAME_W = 8 * RESULT_BYTES;
  localparam int unsigned TXN_W   = $clog2(RESULT_BYTES + 1);

  typedef enum logic [2:0] {
    S_LEN_REF = 3'd0,
    S_LEN_RD  = 3'd1,
    S_REF     = 3'd2,
    S_RD      = 3'd3,
    S_REQ     = 3'd4,
    S_WAIT    = 3'd5,
    S_TX      = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  // Number of packed bytes carrying len bases (4 bases per byte).
  function automatic logic [CNT_W-1:0] len_bytes(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] t;
    t = {1'b0, len} + (LEN_W + 1)'(3);
    return CNT_W'(t >> 2);
  endfunction

  function automatic logic len_ok(input logic [7:0] b);
    return (b != 8'd0) && (b <= 8'(MAX_LEN));
  endfunction

endpackage

// File: rtl/sw_tx_serializer.sv
// Loads a left-aligned byte frame and shifts it out MSB byte first over valid/ready.
// Frame width follows RESULT_BYTES, which grows under SW_BRIDGE_CKSUM_EN.
module sw_tx_serializer
  import sw_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [FRAME_W-1:0] i_frame,
  input  logic [TXN_W-1:0]   i_nbytes,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_done_c
);

  logic [FRAME_W-1:0] shift_q, shift_d;
  logic [TXN_W-1:0]   left_q, left_d;
  logic               valid_q, valid_d;
  logic               fire_c;

  assign fire_c   = valid_q && i_tx_ready;
  assign o_done_c = fire_c && (left_q == TXN_W'(1));

  always_comb begin
    shift_d = shift_q;
    left_d  = left_q;
    valid_d = valid_q;
    if (i_load) begin
      shift_d = i_frame;
      left_d  = i_nbytes;
      valid_d = 1'b1;
    end else if (fire_c) begin
      shift_d = shift_q << 8;
      left_d  = left_q - TXN_W'(1);
      valid_d = (left_q != TXN_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      left_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      left_q  <= left_d;
      valid_q <= valid_d;
    end
  end

  assign o_tx_valid = valid_q;
  assign o_tx_data  = shift_q[FRAME_W-1 -: 8];

endmodule

// File: rtl/sw_host_bridge.sv
// Host-side initiator: unpacks a byte job frame for the SW core and streams the result back.
// Define SW_BRIDGE_CKSUM_EN for a 5-byte result frame (XOR checksum) and a 2-byte error frame.
module sw_host_bridge
  import sw_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_rx_valid,
  output logic               o_rx_ready,
  input  logic [7:0]         i_rx_data,
  output logic               o_core_valid,
  input  logic               i_core_ready,
  output logic [SEQ_W-1:0]   o_seq_ref,
  output logic [SEQ_W-1:0]   o_seq_read,
  output logic [LEN_W-1:0]   o_ref_len,
  output logic [LEN_W-1:0]   o_read_len,
  input  logic               i_core_valid,
  output logic               o_core_ready,
  input  logic [SCORE_W-1:0] i_score,
  input  logic [POS_W-1:0]   i_column,
  input  logic [POS_W-1:0]   i_row,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_busy
);

  state_t             state_q, state_d;
  logic [SEQ_W-1:0]   seq_ref_q, seq_ref_d;
  logic [SEQ_W-1:0]   seq_read_q, seq_read_d;
  logic [LEN_W-1:0]   ref_len_q, ref_len_d;
  logic [LEN_W-1:0]   read_len_q, read_len_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rx_ready_q, rx_ready_d;
  logic               core_valid_q, core_valid_d;
  logic               core_ready_q, core_ready_d;
  logic               busy_q, busy_d;

  logic               rx_fire_c;
  logic [SEQ_W-1:0]   rx_place_c;
  logic               tx_load_c;
  logic               tx_done_c;
  logic [FRAME_W-1:0] tx_frame_c;
  logic [TXN_W-1:0]   tx_nbytes_c;
  logic [FRAME_W-1:0] result_frame_c;
  logic [15:0]        score16_c;
  logic [31:0]        res4_c;

  assign rx_fire_c  = i_rx_valid && rx_ready_q;
  // Byte k of a sequence lands k bytes below the MSB end of its bus.
  assign rx_place_c = SEQ_W'({i_rx_data, {(SEQ_W - 8){1'b0}}} >> {cnt_q, 3'b000});

  assign score16_c = {{(16 - SCORE_W){i_score[SCORE_W-1]}}, i_score};
  assign res4_c    = {score16_c, 8'(i_column), 8'(i_row)};
`ifdef SW_BRIDGE_CKSUM_EN
  assign result_frame_c = {res4_c, res4_c[31:24] ^ res4_c[23:16] ^ res4_c[15:8] ^ res4_c[7:0]};
`else
  assign result_frame_c = res4_c;
`endif

  always_comb begin
    state_d     = state_q;
    seq_ref_d   = seq_ref_q;
    seq_read_d  = seq_read_q;
    ref_len_d   = ref_len_q;
    read_len_d  = read_len_q;
    cnt_d       = cnt_q;
    tx_load_c   = 1'b0;
    tx_frame_c  = '0;
    tx_nbytes_c = '0;

    case (state_q)
      S_LEN_REF: if (rx_fire_c) begin
        seq_ref_d  = '0;
        seq_read_d = '0;
        cnt_d      = '0;
        ref_len_d  = LEN_W'(i_rx_data);
        state_d    = len_ok(i_rx_data) ? S_LEN_RD : S_ERR;
      end
      S_LEN_RD: if (rx_fire_c) begin
        read_len_d = LEN_W'(i_rx_data);
        state_d    = len_ok(i_rx_data) ? S_REF : S_ERR;
      end
      S_REF: if (rx_fire_c) begin
        seq_ref_d = seq_ref_q | rx_place_c;
        if (cnt_q == len_bytes(ref_len_q) - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RD: if (rx_fire_c) begin
        seq_read_d = seq_read_q | rx_place_c;
        if (cnt_q == len_bytes(read_len_q) - CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQ: if (core_valid_q && i_core_ready) state_d = S_WAIT;
      S_WAIT: if (core_ready_q && i_core_valid) begin
        tx_load_c   = 1'b1;
        tx_frame_c  = result_frame_c;
        tx_nbytes_c = TXN_W'(RESULT_BYTES);
        state_d     = S_TX;
      end
      S_TX, S_ERR: if (tx_done_c) state_d = S_LEN_REF;
      default: state_d = S_LEN_REF;
    endcase

    // Both bad-length exits share one error-frame load.
    if (state_d == S_ERR && state_q != S_ERR) begin
      tx_load_c   = 1'b1;
      tx_frame_c  = {{ERR_BYTES{ERR_BYTE}}, {(FRAME_W - 8 * ERR_BYTES){1'b0}}};
      tx_nbytes_c = TXN_W'(ERR_BYTES);
    end

    rx_ready_d   = (state_d == S_LEN_REF) || (state_d == S_LEN_RD) ||
                   (state_d == S_REF) || (state_d == S_RD);
    core_valid_d = (state_d == S_REQ);
    core_ready_d = (state_d == S_WAIT);
    busy_d       = (state_d != S_LEN_REF);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LEN_REF;
      seq_ref_q    <= '0;
      seq_read_q   <= '0;
      ref_len_q    <= '0;
      read_len_q   <= '0;
      cnt_q        <= '0;
      rx_ready_q   <= 1'b0;
      core_valid_q <= 1'b0;
      core_ready_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_ref_q    <= seq_ref_d;
      seq_read_q   <= seq_read_d;
      ref_len_q    <= ref_len_d;
      read_len_q   <= read_len_d;
      cnt_q        <= cnt_d;
      rx_ready_q   <= rx_ready_d;
      core_valid_q <= core_valid_d;
      core_ready_q <= core_ready_d;
      busy_q       <= busy_d;
    end
  end

  sw_tx_serializer u_tx (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (tx_load_c),
    .i_frame    (tx_frame_c),
    .i_nbytes   (tx_nbytes_c),
    .o_tx_valid (o_tx_valid),
    .i_tx_ready (i_tx_ready),
    .o_tx_data  (o_tx_data),
    .o_done_c   (tx_done_c)
  );

  assign o_rx_ready   = rx_ready_q;
  assign o_core_valid = core_valid_q;
  assign o_core_ready = core_ready_q;
  assign o_seq_ref    = seq_ref_q;
  assign o_seq_read   = seq_read_q;
  assign o_ref_len    = ref_len_q;
  assign o_read_len   = read_len_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_sw_host_bridge.sv
// Scoreboard bench for sw_host_bridge: jobs, error frames, tx stalls and mid-frame reset.
// Honours SW_BRIDGE_CKSUM_EN for the expected tx frames.
module tb_sw_host_bridge;
  import sw_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               i_rx_valid = 1'b0;
  logic               o_rx_ready;
  logic [7:0]         i_rx_data = '0;
  logic               o_core_valid;
  logic               i_core_ready = 1'b0;
  logic [SEQ_W-1:0]   o_seq_ref, o_seq_read;
  logic [LEN_W-1:0]   o_ref_len, o_read_len;
  logic               i_core_valid = 1'b0;
  logic               o_core_ready;
  logic [SCORE_W-1:0] i_score = '0;
  logic [POS_W-1:0]   i_column = '0;
  logic [POS_W-1:0]   i_row = '0;
  logic               o_tx_valid;
  logic               i_tx_ready = 1'b0;
  logic [7:0]         o_tx_data;
  logic               o_busy;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] ref_b[32];
  logic [7:0] rd_b[32];
  bit tx_rand = 0;
  bit core_valid_seen = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data = '0;

  always #5 clk = ~clk;

  sw_host_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready), .i_rx_data(i_rx_data),
    .o_core_valid(o_core_valid), .i_core_ready(i_core_ready),
    .o_seq_ref(o_seq_ref), .o_seq_read(o_seq_read),
    .o_ref_len(o_ref_len), .o_read_len(o_read_len),
    .i_core_valid(i_core_valid), .o_core_ready(o_core_ready),
    .i_score(i_score), .i_column(i_column), .i_row(i_row),
    .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready), .o_tx_data(o_tx_data),
    .o_busy(o_busy)
  );

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // tx sink: chooses ready, then pops/compares any byte that will move at the next edge.
  always @(negedge clk) begin
    if (o_core_valid) core_valid_seen = 1;
    if (prev_stall && o_tx_valid) check_eq("tx_stall_hold", 256'(o_tx_data), 256'(prev_data));
    i_tx_ready = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (o_tx_valid && i_tx_ready) begin
      if (exp_q.size() == 0) check_eq("tx_unexpected", 256'(o_tx_data), 256'h100);
      else check_eq("tx_byte", 256'(o_tx_data), 256'(exp_q.pop_front()));
    end
    prev_stall = o_tx_valid && !i_tx_ready;
    prev_data  = o_tx_data;
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    while (!o_rx_ready && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) check_eq("rx_ready_timeout", 256'(o_rx_ready), 256'(1));
    @(negedge clk);
    i_rx_valid = 1'b0;
  endtask

  task automatic drain_tx();
    int n = 0;
    while ((exp_q.size() != 0 || o_tx_valid) && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check_eq("tx_drain_timeout", 256'(exp_q.size()), 256'(0));
  endtask

  task automatic push_result(input int sc, input int col, input int row);
    logic [15:0] s16;
    logic [7:0]  c8, r8;
    s16 = 16'(sc);
    c8  = 8'(col);
    r8  = 8'(row);
    exp_q.push_back(s16[15:8]);
    exp_q.push_back(s16[7:0]);
    exp_q.push_back(c8);
    exp_q.push_back(r8);
`ifdef SW_BRIDGE_CKSUM_EN
    exp_q.push_back(s16[15:8] ^ s16[7:0] ^ c8 ^ r8);
`endif
  endtask

  task automatic push_err();
    exp_q.push_back(8'hEE);
`ifdef SW_BRIDGE_CKSUM_EN
    exp_q.push_back(8'hEE);
`endif
  endtask

  task automatic run_job(input int rl, input int dl, input int sc, input int col,
                         input int row, input int hold);
    logic [SEQ_W-1:0] er, ed, snap_r, snap_d;
    bit stable = 1;
    int n = 0;
    er = '0;
    ed = '0;
    send_byte(8'(rl));
    send_byte(8'(dl));
    for (int k = 0; k < (rl + 3) / 4; k++) begin
      send_byte(ref_b[k]);
      er[SEQ_W - 1 - 8 * k -: 8] = ref_b[k];
    end
    for (int k = 0; k < (dl + 3) / 4; k++) begin
      send_byte(rd_b[k]);
      ed[SEQ_W - 1 - 8 * k -: 8] = rd_b[k];
    end
    check_eq("core_valid_latency", 256'(o_core_valid), 256'(1));
    check_eq("rx_ready_in_req", 256'(o_rx_ready), 256'(0));
    check_eq("seq_ref", 256'(o_seq_ref), 256'(er));
    check_eq("seq_read", 256'(o_seq_read), 256'(ed));
    check_eq("ref_len", 256'(o_ref_len), 256'(rl));
    check_eq("read_len", 256'(o_read_len), 256'(dl));
    snap_r = o_seq_ref;
    snap_d = o_seq_read;
    for (int c = 0; c < hold; c++) begin
      i_core_valid = (c == 1);
      @(negedge clk);
      if (o_seq_ref !== snap_r || o_seq_read !== snap_d || !o_core_valid ||
          o_ref_len !== LEN_W'(rl) || o_read_len !== LEN_W'(dl)) stable = 0;
    end
    i_core_valid = 1'b0;
    check_eq("req_hold_stable", 256'(stable), 256'(1));
    i_core_ready = 1'b1;
    @(negedge clk);
    i_core_ready = 1'b0;
    while (!o_core_ready && n < 50) begin @(negedge clk); n++; end
    check_eq("core_ready_wait", 256'(o_core_ready), 256'(1));
    check_eq("core_valid_dropped", 256'(o_core_valid), 256'(0));
    push_result(sc, col, row);
    i_score      = SCORE_W'(sc);
    i_column     = POS_W'(col);
    i_row        = POS_W'(row);
    i_core_valid = 1'b1;
    @(negedge clk);
    i_core_valid = 1'b0;
    drain_tx();
    check_eq("idle_after_job", 256'(o_busy), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(negedge clk);
    check_eq("rst_busy", 256'(o_busy), 256'(0));
    check_eq("rst_rx_ready", 256'(o_rx_ready), 256'(0));
    check_eq("rst_tx_valid", 256'(o_tx_valid), 256'(0));
    check_eq("rst_core_valid", 256'(o_core_valid), 256'(0));
    check_eq("rst_seq_ref", 256'(o_seq_ref), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 4-base job, then a negative-score result under random tx backpressure.
    ref_b[0] = 8'h1B; rd_b[0] = 8'h1B;
    run_job(4, 4, 4, 3, 3, 2);
    tx_rand = 1;
    ref_b[0] = 8'hE4; ref_b[1] = 8'h5A; rd_b[0] = 8'hC3;
    run_job(7, 3, -5, 127, 0, 3);

    // Bad lengths produce only the error frame and no core job.
    foreach (ref_b[i]) ref_b[i] = 8'(i * 7 + 1);
    for (int t = 0; t < 2; t++) begin
      core_valid_seen = 0;
      push_err();
      send_byte(t == 0 ? 8'd0 : 8'd129);
      drain_tx();
      check_eq("err_no_core_valid", 256'(core_valid_seen), 256'(0));
      check_eq("err_idle", 256'(o_busy), 256'(0));
    end
    core_valid_seen = 0;
    push_err();
    send_byte(8'd8);
    send_byte(8'd200);
    drain_tx();
    check_eq("err_rdlen_no_core", 256'(core_valid_seen), 256'(0));
    rd_b[0] = 8'h3C; rd_b[1] = 8'h99;
    run_job(5, 6, 100, 4, 5, 1);

    // Full-length sequences with a long core stall.
    foreach (ref_b[i]) ref_b[i] = 8'($urandom);
    foreach (rd_b[i]) rd_b[i] = 8'($urandom);
    run_job(128, 128, 511, 127, 127, 10);

    // Reset mid-frame discards everything.
    tx_rand = 0;
    send_byte(8'd16);
    send_byte(8'd4);
    for (int k = 0; k < 3; k++) send_byte(ref_b[k]);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 256'(o_busy), 256'(0));
    check_eq("midrst_seq_ref", 256'(o_seq_ref), 256'(0));
    check_eq("midrst_ref_len", 256'(o_ref_len), 256'(0));
    check_eq("midrst_rx_ready", 256'(o_rx_ready), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("postrst_rx_ready", 256'(o_rx_ready), 256'(1));
    run_job(16, 4, -512, 1, 2, 2);

    check_eq("queue_empty", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
